seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
Runtime-programmable serial bit-sequence detector for a 1-bit stream. It matches any pattern of 1..MAX_LEN bits and supports selectable overlapping or non-overlapping detection. It has a Moore-style registered detect pulse, an input-valid qualifier and a saturating match counter. It replaces the fixed-pattern 1011 detectors and resets to the 1011 non-overlapping configuration.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must hold MAX_LEN
CNT_W, 16, match counter width
RST_PAT, 8'b0000_1011, pattern loaded at reset (LSB-aligned)
RST_LEN, 4, pattern length loaded at reset
RST_OVL, 0, overlap mode loaded at reset (0 = non-overlapping)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
din_vld  in  1  din is sampled only when high
din  in  1  serial data bit
cfg_load  in  1  one-cycle strobe: latch cfg_pat/cfg_len/cfg_ovl, clear history
cfg_pat  in  MAX_LEN  new pattern; bit cfg_len-1 is the first bit in time, bit 0 the last
cfg_len  in  LEN_W  new pattern length
cfg_ovl  in  1  new mode: 1 = overlapping, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_cnt
det  out  1  registered match pulse, one cycle per match
match_cnt  out  CNT_W  saturating count of matches
cur_len  out  LEN_W  active pattern length (effective, after clamp)

Behaviour:
- Reset (rst=1 at rising edge):
  - pat=RST_PAT, len=RST_LEN, ovl=RST_OVL.
  - History shift register hist=0, fill counter fill=0.
  - det=0, match_cnt=0.
  - rst overrides every other input.
- Config clamp: cfg_len>MAX_LEN is stored as MAX_LEN. cfg_len=0 is stored as 0, and the block then never matches; cur_len reflects the stored value.
- cfg_load cycle:
  - Latch the config and clear hist, fill and det.
  - din is discarded even if din_vld=1.
  - match_cnt is not affected.
  - cfg_load has priority over din_vld.
- Sample cycle (din_vld=1, no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], din}; fill_n = min(fill+1, MAX_LEN).
  - match = (len!=0) && (fill_n>=len) && (hist_n[len-1:0]==pat[len-1:0]).
  - On match:
    - det<=1 on the next edge, so det is high during the cycle after the edge that sampled the final bit. This is a Moore output: no combinational path from din to det.
    - match_cnt increments; it holds at 2^CNT_W-1 with no wrap.
    - ovl=1: hist<=hist_n and fill<=fill_n, so trailing bits may start the next match.
    - ovl=0: fill<=0, so the next match needs len fresh valid bits.
  - No match: det<=0, hist<=hist_n, fill<=fill_n.
- Idle cycle (din_vld=0): hist and fill hold, det<=0. Gaps in din_vld are transparent to matching.
- cnt_clr: match_cnt<=0 that cycle. If a match occurs in the same cycle, match_cnt<=1 (clear then count).
- Back-to-back matches (ovl=1, e.g. len=1): det stays high on consecutive cycles, one cycle per match.
- Latency: final pattern bit sampled at edge N; det=1 and updated match_cnt are visible after edge N, for the cycle N..N+1.
- Reset mid-stream: a partial match is lost, a pending det is cleared, and the config reverts to RST_*.
- Internal controller: explicit state register with states IDLE (fill==0), FILL (0<fill<len) and ARMED (fill>=len). Transitions follow the fill counter; det is a registered output of the MATCH condition.

Test Plan:
- Reset defaults, ovl=0: din_vld=1, stream 1,0,1,1,0,1,1 -> det pulses once, the cycle after bit 4; match_cnt=1; cur_len=4.
- Same stream after cfg_load with pat=4'b1011, len=4, ovl=1 -> det pulses after bit 4 and after bit 7; match_cnt=2.
- din_vld gaps: stream 1,0,1,1 with din_vld=0 for 3 cycles between each bit -> exactly one det pulse, one cycle after the last valid sample; det is never high during idle cycles.
- cfg_load pat=8'b1100_1010, len=8, ovl=0, then 16 bits repeating 11001010 -> det after bit 8 and bit 16. cfg_load pulsed after bit 5 of a third copy -> no det for that copy.
- CNT_W=2, len=1, pat=1, ovl=1: stream of 6 ones -> det high 6 consecutive cycles; match_cnt goes 1,2,3,3,3,3. Then cnt_clr together with a matching bit -> match_cnt=1.
- Edge cases:
  - cfg_len=0 with any stream -> det never asserted.
  - cfg_len=15 -> cur_len=MAX_LEN=8.
  - rst asserted one bit before a match completes -> no det, match_cnt=0, config back to 1011/4/non-overlap.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with overlap control,
// registered detect pulse and saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b1011),
  parameter int                 RST_LEN = 4,
  parameter bit                 RST_OVL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_vld,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               det,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   cur_len
);

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat, hist, hist_n, hist_d, mask;
  logic [LEN_W-1:0]   len, len_d, fill, fill_n, fill_d;
  logic               ovl;
  logic               match_p0;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
    if (int'(f) >= MAX_LEN) return f;
    return f + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage 0: candidate history, match decision and next fill/state
  always_comb begin
    hist_n   = {hist[MAX_LEN-2:0], din};
    fill_n   = fill_inc(fill);
    mask     = ~({MAX_LEN{1'b1}} << len);
    match_p0 = din_vld && !cfg_load && (len != '0) &&
               ((state == ARMED) || (fill_n >= len)) &&
               (((hist_n ^ pat) & mask) == '0);

    hist_d = hist;
    fill_d = fill;
    len_d  = len;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      len_d  = clamp_len(cfg_len);
    end else if (din_vld) begin
      hist_d = hist_n;
      fill_d = (match_p0 && !ovl) ? '0 : fill_n;
    end

    state_n = FILL;
    if (fill_d == '0)        state_n = IDLE;
    else if (fill_d >= len_d) state_n = ARMED;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Stage 1: registered history, config, detect pulse and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= RST_PAT;
      len  <= LEN_W'(RST_LEN);
      ovl  <= RST_OVL;
      hist <= '0;
      fill <= '0;
      det  <= 1'b0;
      cnt  <= '0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      det  <= match_p0;
      if (cfg_load) begin
        pat <= cfg_pat;
        len <= len_d;
        ovl <= cfg_ovl;
      end
      if (cnt_clr)       cnt <= match_p0 ? CNT_W'(1) : '0;
      else if (match_p0) cnt <= sat_inc(cnt);
    end
  end

  assign match_cnt = cnt;
  assign cur_len   = len;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a wide-counter and a 2-bit-counter
// instance share stimulus; directed vectors carry hand-computed det values.
module tb_seq_detect_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_vld = 1'b0;
  logic        din = 1'b0;
  logic        cfg_load = 1'b0;
  logic [7:0]  cfg_pat = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_ovl = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        det, det2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [3:0]  cur_len, cur_len2;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .det(det), .match_cnt(cnt), .cur_len(cur_len)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .det(det2), .match_cnt(cnt2), .cur_len(cur_len2)
  );

  typedef struct {
    logic        det;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [3:0]  len;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          sid = 0;
  logic [15:0] ecnt = '0;
  logic [1:0]  ecnt2 = '0;
  logic [3:0]  elen = 4'd4;

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge after each active edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("det", e.id, {15'd0, det}, {15'd0, e.det});
      chk("det_cw2", e.id, {15'd0, det2}, {15'd0, e.det});
      chk("match_cnt", e.id, cnt, e.cnt);
      chk("match_cnt_cw2", e.id, {14'd0, cnt2}, {14'd0, e.cnt2});
      chk("cur_len", e.id, {12'd0, cur_len}, {12'd0, e.len});
    end
  end

  task automatic step(input logic v, input logic b, input logic e_det);
    din_vld = v;
    din     = b;
    @(posedge clk);
    if (rst) begin
      ecnt  = '0;
      ecnt2 = '0;
    end else if (cnt_clr) begin
      ecnt  = e_det ? 16'd1 : 16'd0;
      ecnt2 = e_det ? 2'd1 : 2'd0;
    end else if (e_det) begin
      ecnt = ecnt + 16'd1;
      if (ecnt2 != 2'd3) ecnt2 = ecnt2 + 2'd1;
    end
    q.push_back('{e_det, ecnt, ecnt2, elen, sid});
    sid++;
    #1;
    rst = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; din_vld = 1'b0; din = 1'b0;
  endtask

  task automatic rst_step(input logic v, input logic b);
    rst  = 1'b1;
    elen = 4'd4;
    step(v, b, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic [3:0] exp_len, input logic clr);
    cfg_pat  = p;
    cfg_len  = l;
    cfg_ovl  = o;
    cfg_load = 1'b1;
    cnt_clr  = clr;
    elen     = exp_len;
    step(1'b1, 1'b1, 1'b0);
  endtask

  // bits are sent MSB first; dets[i] is the expected det after bits[i]
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] dets);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], dets[i]);
  endtask

  initial begin
    rst_step(1'b0, 1'b0);

    // Reset defaults: 1011, non-overlapping
    stream(16'b1011011, 7, 16'b0001000);

    // Overlapping 1011
    load(8'b0000_1011, 4'd4, 1'b1, 4'd4, 1'b1);
    stream(16'b1011011, 7, 16'b0001001);

    // din_vld gaps are transparent; det never high in idle cycles
    load(8'b0000_1011, 4'd4, 1'b0, 4'd4, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Full-length pattern, cfg_load mid-copy discards the partial match
    load(8'b1100_1010, 4'd8, 1'b0, 4'd8, 1'b0);
    stream(16'hCACA, 16, 16'h0101);
    stream(16'b11001, 5, 16'h0000);
    load(8'b1100_1010, 4'd8, 1'b0, 4'd8, 1'b0);
    stream(16'b010, 3, 16'h0000);
    stream(16'h00CA, 8, 16'h0001);

    // len=1 back-to-back matches and counter saturation, then clear+count
    load(8'h01, 4'd1, 1'b1, 4'd1, 1'b1);
    stream(16'b111111, 6, 16'b111111);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // len=0 never matches
    load(8'h00, 4'd0, 1'b1, 4'd0, 1'b0);
    stream(16'hB40F, 16, 16'h0000);

    // len clamp to MAX_LEN
    load(8'hFF, 4'd15, 1'b0, 4'd8, 1'b0);
    stream(16'h00FF, 8, 16'h0001);
    stream(16'h007F, 7, 16'h0000);

    // Reset on the bit that would complete the match; config reverts
    rst_step(1'b1, 1'b1);
    stream(16'b1011011, 7, 16'b0001000);

    repeat (3) @(negedge clk);
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
